// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one data-memory port among
// several dcache memory-side interfaces. One transaction (read fill or
// write-through store) is in flight at a time. It also keeps grant and
// contention statistics.
module dmem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready,
  output logic [31:0]                        grant_count,
  output logic [31:0]                        contention_cycles
);

  localparam int IDXW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_READ_ACCEPT = 3'd1;
  localparam logic [2:0] S_READ_WAIT   = 3'd2;
  localparam logic [2:0] S_WRITE_WAIT  = 3'd3;
  localparam logic [2:0] S_RELEASE     = 3'd4;

  // Per-consumer views of the flattened request buses
  logic [ADDR_BITS-1:0] rd_addr_s [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0] wr_addr_s [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] wr_data_s [NUM_CONSUMERS];

  logic [2:0]               state_q, state_d;
  logic [IDXW-1:0]          g_q, g_d;
  logic [IDXW-1:0]          rr_q, rr_d;
  logic [NUM_CONSUMERS-1:0] rd_ready_q, rd_ready_d;
  logic [NUM_CONSUMERS-1:0] wr_ready_q, wr_ready_d;
  logic [DATA_BITS-1:0]     rd_data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     rd_data_d [NUM_CONSUMERS];
  logic                     mem_rv_q, mem_rv_d;
  logic [ADDR_BITS-1:0]     mem_ra_q, mem_ra_d;
  logic                     mem_wv_q, mem_wv_d;
  logic [ADDR_BITS-1:0]     mem_wa_q, mem_wa_d;
  logic [DATA_BITS-1:0]     mem_wd_q, mem_wd_d;
  logic [31:0]              grant_q, grant_d;
  logic [31:0]              cont_q, cont_d;

  logic [NUM_CONSUMERS-1:0] req_s;
  logic                     found_s;
  logic [IDXW-1:0]          win_s;
  logic [IDXW-1:0]          scan_idx_s;
  int                       scan_sum_s;
  logic [IDXW-1:0]          act_s;
  logic                     other_s;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_slices
      assign rd_addr_s[gi] = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
      assign wr_addr_s[gi] = consumer_write_address[gi*ADDR_BITS +: ADDR_BITS];
      assign wr_data_s[gi] = consumer_write_data[gi*DATA_BITS +: DATA_BITS];
      assign consumer_read_data[gi*DATA_BITS +: DATA_BITS] = rd_data_q[gi];
    end
  endgenerate

  assign req_s = consumer_read_valid | consumer_write_valid;

  // Round-robin scan: first requester at or after rr wins
  always_comb begin
    found_s    = 1'b0;
    win_s      = {IDXW{1'b0}};
    scan_idx_s = {IDXW{1'b0}};
    scan_sum_s = 0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      scan_sum_s = int'(rr_q) + i;
      if (scan_sum_s >= NUM_CONSUMERS) begin
        scan_sum_s = scan_sum_s - NUM_CONSUMERS;
      end else begin
        scan_sum_s = scan_sum_s;
      end
      scan_idx_s = IDXW'(scan_sum_s);
      if (!found_s && req_s[scan_idx_s]) begin
        found_s = 1'b1;
        win_s   = scan_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Contention: someone other than the consumer being served is requesting
  always_comb begin
    act_s   = (state_q == S_IDLE) ? win_s : g_q;
    other_s = 1'b0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (req_s[i] && (IDXW'(i) != act_s)) begin
        other_s = 1'b1;
      end else begin
        other_s = other_s;
      end
    end
  end

  // Transaction sequencing and next-state computation
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    rr_d       = rr_q;
    rd_ready_d = rd_ready_q;
    wr_ready_d = wr_ready_q;
    rd_data_d  = rd_data_q;
    mem_rv_d   = mem_rv_q;
    mem_ra_d   = mem_ra_q;
    mem_wv_d   = mem_wv_q;
    mem_wa_d   = mem_wa_q;
    mem_wd_d   = mem_wd_q;
    grant_d    = grant_q;
    cont_d     = other_s ? (cont_q + 32'd1) : cont_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          g_d = win_s;
          // Within one consumer a pending store goes before a fill
          if (consumer_write_valid[win_s]) begin
            mem_wa_d = wr_addr_s[win_s];
            mem_wd_d = wr_data_s[win_s];
            mem_wv_d = 1'b1;
            state_d  = S_WRITE_WAIT;
          end else begin
            mem_ra_d          = rd_addr_s[win_s];
            rd_ready_d[win_s] = 1'b1;
            state_d           = S_READ_ACCEPT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ_ACCEPT: begin
        rd_ready_d[g_q] = 1'b0;
        mem_rv_d        = 1'b1;
        state_d         = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        if (mem_read_ready) begin
          rd_data_d[g_q]  = mem_read_data;
          rd_ready_d[g_q] = 1'b1;
          mem_rv_d        = 1'b0;
          state_d         = S_RELEASE;
        end else begin
          state_d = S_READ_WAIT;
        end
      end
      S_WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_wv_d        = 1'b0;
          wr_ready_d[g_q] = 1'b1;
          state_d         = S_RELEASE;
        end else begin
          state_d = S_WRITE_WAIT;
        end
      end
      S_RELEASE: begin
        rd_ready_d = {NUM_CONSUMERS{1'b0}};
        wr_ready_d = {NUM_CONSUMERS{1'b0}};
        grant_d    = grant_q + 32'd1;
        if (g_q == IDXW'(NUM_CONSUMERS - 1)) begin
          rr_d = {IDXW{1'b0}};
        end else begin
          rr_d = g_q + IDXW'(1);
        end
        state_d = S_IDLE;
      end
      default: begin
        rd_ready_d = {NUM_CONSUMERS{1'b0}};
        wr_ready_d = {NUM_CONSUMERS{1'b0}};
        mem_rv_d   = 1'b0;
        mem_wv_d   = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      g_q        <= {IDXW{1'b0}};
      rr_q       <= {IDXW{1'b0}};
      rd_ready_q <= {NUM_CONSUMERS{1'b0}};
      wr_ready_q <= {NUM_CONSUMERS{1'b0}};
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        rd_data_q[i] <= {DATA_BITS{1'b0}};
      end
      mem_rv_q   <= 1'b0;
      mem_ra_q   <= {ADDR_BITS{1'b0}};
      mem_wv_q   <= 1'b0;
      mem_wa_q   <= {ADDR_BITS{1'b0}};
      mem_wd_q   <= {DATA_BITS{1'b0}};
      grant_q    <= 32'd0;
      cont_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      rr_q       <= rr_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      rd_data_q  <= rd_data_d;
      mem_rv_q   <= mem_rv_d;
      mem_ra_q   <= mem_ra_d;
      mem_wv_q   <= mem_wv_d;
      mem_wa_q   <= mem_wa_d;
      mem_wd_q   <= mem_wd_d;
      grant_q    <= grant_d;
      cont_q     <= cont_d;
    end
  end

  assign consumer_read_ready  = rd_ready_q;
  assign consumer_write_ready = wr_ready_q;
  assign mem_read_valid       = mem_rv_q;
  assign mem_read_address     = mem_ra_q;
  assign mem_write_valid      = mem_wv_q;
  assign mem_write_address    = mem_wa_q;
  assign mem_write_data       = mem_wd_q;
  assign grant_count          = grant_q;
  assign contention_cycles    = cont_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios, a transaction-timeline model
// checked every cycle, and hand-computed literal expectations.
module tb_dmem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]    rv, wv;
  logic [N*AW-1:0] raddr, waddr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    crr, cwr;
  logic [N*DW-1:0] crd;
  logic            mrv, mrr, mwv, mwr;
  logic [AW-1:0]   mra, mwa;
  logic [DW-1:0]   mrd, mwd;
  logic [31:0]     gcnt, ccnt;

  always #5 clk = ~clk;

  dmem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(raddr),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(wv), .consumer_write_address(waddr),
    .consumer_write_data(wdata), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr),
    .grant_count(gcnt), .contention_cycles(ccnt)
  );

  int vec = 0;
  int mis = 0;

  // ---------------- timeline model ----------------
  // A transaction is described by who owns it (cur), its kind (wr), the edge
  // it was granted (tg) and the edge the memory answer was taken (td).
  int          n = 0, cur = -1, tg = 0, td = -1, m_rr = 0;
  bit          wr = 1'b0, model_ok = 1'b0;
  logic [31:0] m_gc = 32'd0, m_cc = 32'd0;
  logic [N*DW-1:0] m_rd = '0;
  logic [AW-1:0]   m_mra = '0, m_mwa = '0;
  logic [DW-1:0]   m_mwd = '0;

  always @(posedge clk) begin : model
    int win, act, idx;
    logic [N-1:0] req;
    bit other;
    n = n + 1;
    if (reset) begin
      cur = -1; td = -1; wr = 1'b0; m_rr = 0;
      m_gc = 32'd0; m_cc = 32'd0; m_rd = '0;
      m_mra = '0; m_mwa = '0; m_mwd = '0;
      model_ok = 1'b1;
    end else begin
      req = rv | wv;
      win = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (win < 0 && req[idx]) win = idx;
      end
      act = (cur >= 0) ? cur : win;
      other = 1'b0;
      for (int k = 0; k < N; k++) if (req[k] && k != act) other = 1'b1;
      if (other) m_cc = m_cc + 32'd1;
      if (cur < 0) begin
        if (win >= 0) begin
          cur = win; tg = n; td = -1; wr = wv[win];
          if (wr) begin
            m_mwa = waddr[win*AW +: AW];
            m_mwd = wdata[win*DW +: DW];
          end else begin
            m_mra = raddr[win*AW +: AW];
          end
        end
      end else if (td < 0) begin
        if (wr && n >= tg + 1 && mwr) td = n;
        if (!wr && n >= tg + 2 && mrr) begin
          td = n;
          m_rd[cur*DW +: DW] = mrd;
        end
      end else begin
        m_gc = m_gc + 32'd1;
        m_rr = (cur + 1) % N;
        cur = -1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [N-1:0] e_rr, e_wr;
    bit e_mrv, e_mwv;
    if (model_ok) begin
      e_rr = '0; e_wr = '0;
      if (cur >= 0) begin
        if (!wr && (n == tg || (td >= 0 && n == td))) e_rr[cur] = 1'b1;
        if (wr && td >= 0 && n == td) e_wr[cur] = 1'b1;
      end
      e_mrv = (cur >= 0) && !wr && (n >= tg + 1) && (td < 0);
      e_mwv = (cur >= 0) && wr && (td < 0);
      chk("m_read_ready", crr, e_rr);
      chk("m_write_ready", cwr, e_wr);
      chk("m_mem_read_valid", mrv, e_mrv);
      chk("m_mem_write_valid", mwv, e_mwv);
      chk("m_mem_read_address", mra, m_mra);
      chk("m_mem_write_address", mwa, m_mwa);
      chk("m_mem_write_data", mwd, m_mwd);
      chk("m_read_data", crd, m_rd);
      chk("m_grant_count", gcnt, m_gc);
      chk("m_contention", ccnt, m_cc);
    end
  endtask

  // ---------------- environment ----------------
  logic [DW-1:0] mem_arr [256];
  bit auto_drop, mem_auto, mem_pulse;
  int mem_lat, rcnt = 0, wcnt = 0;
  int gorder [32];
  int gn = 0, prev_idx = -1;
  bit prev_mrv = 1'b0;

  task automatic tick();
    @(negedge clk);
    compare();
    if (!prev_mrv && mrv && gn < 32) begin
      gorder[gn] = prev_idx;
      gn++;
    end
    prev_mrv = mrv;
    for (int k = 0; k < N; k++) if (crr[k]) prev_idx = k;
    if (auto_drop) begin
      rv = rv & ~crr;
      wv = wv & ~cwr;
    end
    mrd = mem_arr[mra];
    if (mrr) begin
      mrr = 1'b0; rcnt = 0;
    end else if (mem_pulse) begin
      mrr = 1'b1; mem_pulse = 1'b0;
    end else if (mem_auto && mrv) begin
      rcnt++;
      if (rcnt > mem_lat) mrr = 1'b1;
    end else begin
      rcnt = 0;
    end
    if (mwr) begin
      mwr = 1'b0; wcnt = 0;
    end else if (mem_auto && mwv) begin
      wcnt++;
      if (wcnt > mem_lat) begin
        mwr = 1'b1;
        mem_arr[mwa] = mwd;
      end
    end else begin
      wcnt = 0;
    end
  endtask

  task automatic wait_gc(input logic [31:0] target, input string nm);
    int k;
    k = 0;
    while (gcnt != target && k < 60) begin tick(); k++; end
    chk(nm, gcnt, target);
  endtask

  initial begin : stim
    int k, base;
    logic [31:0] c0;
    reset = 1'b1; rv = '0; wv = '0; raddr = '0; waddr = '0; wdata = '0;
    mrr = 1'b0; mwr = 1'b0; mrd = '0;
    auto_drop = 1'b1; mem_auto = 1'b1; mem_pulse = 1'b0; mem_lat = 1;
    for (int a = 0; a < 256; a++) mem_arr[a] = 8'(a * 7 + 3);
    mem_arr[8'h3C] = 8'hA5;
    tick(); tick();
    reset = 1'b0;
    chk("reset_grant_count", gcnt, 32'd0);
    chk("reset_contention", ccnt, 32'd0);
    chk("reset_readies", {crr, cwr, mrv, mwv}, 10'd0);

    // Single read: consumer 1, address 0x3C, memory answers 0xA5
    raddr[1*AW +: AW] = 8'h3C; rv = 4'b0010;
    tick();
    chk("read_accept_pulse", crr, 4'b0010);
    k = 0;
    do begin tick(); k++; end while (crr == 4'b0000 && k < 20);
    chk("read_data_pulse", crr, 4'b0010);
    chk("read_data_c1", crd[15:8], 8'hA5);
    tick();
    chk("read_grant_count", gcnt, 32'd1);

    // Single write: consumer 0 stores 0x55 at 0x10, memory slow
    mem_lat = 3;
    waddr[0 +: AW] = 8'h10; wdata[0 +: DW] = 8'h55; wv = 4'b0001;
    tick();
    chk("write_valid", mwv, 1'b1);
    chk("write_addr_data", {mwa, mwd}, 16'h1055);
    k = 0;
    while (cwr == 4'b0000 && k < 20) begin tick(); k++; end
    chk("write_ready_pulse", cwr, 4'b0001);
    wait_gc(32'd2, "write_grant_count");
    mem_lat = 1;

    // Same consumer read+write: store served first, then the fill sees it
    raddr[2*AW +: AW] = 8'h20; waddr[2*AW +: AW] = 8'h20; wdata[2*DW +: DW] = 8'h77;
    rv = 4'b0100; wv = 4'b0100;
    k = 0;
    while ((crr | cwr) == 4'b0000 && k < 30) begin tick(); k++; end
    chk("rw_first_is_write", {crr, cwr}, 8'b0000_0100);
    wait_gc(32'd4, "rw_grant_count");
    chk("rw_read_data_c2", crd[23:16], 8'h77);
    tick(); tick();

    // Wrap: rr is now 3, consumers 0 and 3 request together
    raddr[0 +: AW] = 8'h01; raddr[3*AW +: AW] = 8'h03; rv = 4'b1001;
    base = gn;
    wait_gc(32'd6, "wrap_grant_count");
    chk("wrap_first", gorder[base], 3);
    chk("wrap_second", gorder[base+1], 0);
    tick(); tick();

    // Reset in the middle of a read, then a stray memory response
    mem_auto = 1'b0;
    raddr[1*AW +: AW] = 8'h3C; rv = 4'b0010;
    k = 0;
    while (!mrv && k < 10) begin tick(); k++; end
    chk("reach_read_wait", mrv, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0; rv = '0;
    chk("rst_readies", {crr, cwr, mrv, mwv}, 10'd0);
    chk("rst_counters", {gcnt, ccnt}, 64'd0);
    chk("rst_read_data", crd, 32'd0);
    chk("rst_mem_addr", {mra, mwa, mwd}, 24'd0);
    mem_pulse = 1'b1;
    tick(); tick(); tick();
    chk("late_resp_ignored", {crr, mrv}, 5'd0);
    chk("late_resp_count", gcnt, 32'd0);
    mem_auto = 1'b1;

    // Fairness: all four hold read_valid
    auto_drop = 1'b0;
    rv = 4'b1111;
    base = gn;
    c0 = ccnt;
    for (int j = 0; j < 10; j++) tick();
    chk("contention_every_cycle", ccnt - c0, 32'd10);
    k = 0;
    while (gn < base + 5 && k < 80) begin tick(); k++; end
    chk("fair_0", gorder[base], 0);
    chk("fair_1", gorder[base+1], 1);
    chk("fair_2", gorder[base+2], 2);
    chk("fair_3", gorder[base+3], 3);
    chk("fair_4", gorder[base+4], 0);
    rv = '0; auto_drop = 1'b1;
    for (int j = 0; j < 8; j++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule
